mips_data_bus_responder: RTL
============================

# mips_data_bus_responder

Memory-mapped data-bus responder for the pipelined MIPS core. It serves the MEM-stage accesses the core issues: the core's MemRead/MemWrite strobes, the ALU result as the address, and ReadData2 as the store data. It returns MemoryData in the same cycle. Behind the bus it holds:

- the word-addressed data RAM;
- the PortOut register;
- a synchronized PortIn with sticky change flags;
- a compare timer.

It replaces the core's tied-off PortOut.

## Interface
Parameters:
- MEMORY_DEPTH, 512, data RAM depth in 32-bit words.
- DATA_BASE, 32'h1001_0000, byte address of RAM word 0.
- IO_BASE, 32'hFFFF_0000, byte address of the I/O register block.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load strobe from the MEM stage.
- MemWrite  in  1  store strobe from the MEM stage.
- ALUResult  in  32  byte address; bits [1:0] ignored.
- ReadData2  in  32  store data.
- PortIn  in  8  asynchronous external pins.
- MemoryData  out  32  load data, combinational from the address.
- PortOut  out  32  PORT_OUT register contents.
- BusError  out  1  registered one-cycle pulse after an access to an unmapped address.

## Operation
- Decode, with word address = ALUResult[31:2]:
  - RAM hit when DATA_BASE ≤ addr < DATA_BASE + 4·MEMORY_DEPTH.
  - I/O hit when addr is IO_BASE + 0x00 … 0x14.
  - Anything else is unmapped.
- I/O registers (offset, access, reset value):
  - 0x00 PORT_OUT, RW, 0.
  - 0x04 PORT_IN, RO, {24'b0, sync2}.
  - 0x08 PIN_EVT, RW1C, bits[7:0] sticky per-pin change flags, 0.
  - 0x0C TIMER_CNT, RW, 0.
  - 0x10 TIMER_CMP, RW, 32'hFFFF_FFFF.
  - 0x14 CTRL:
    - bit0 TMR_EN, RW, reset 0.
    - bit1 MATCH, sticky; writing 1 clears it.
    - bits[31:2] read 0.
- Loads:
  - MemoryData is valid in the same cycle that MemRead is high.
  - MemoryData is 0 when MemRead is low or the address is unmapped.
  - Reads have no side effects.
- Stores: take effect on the rising edge while MemWrite is high. Stores to read-only or unmapped locations are ignored.
- MemRead and MemWrite both high: the write happens and MemoryData shows the pre-write value.
- BusError: set for one cycle on the edge after any strobe (MemRead or MemWrite) to an unmapped address.
- PortIn path:
  - Two flops give sync1 then sync2; a third flop gives prev.
  - PIN_EVT[i] is set when sync2[i] ≠ prev[i].
  - Set and W1C clear in the same cycle: set wins.
- Timer:
  - Holds while TMR_EN = 0.
  - While enabled, it increments each cycle.
  - When CNT == CMP, the next value is 0 and MATCH is set.
  - A CPU write to TIMER_CNT overrides the increment/wrap in that cycle. MATCH is still set from the pre-write compare.
  - MATCH set and W1C in the same cycle: set wins.
- Width rules: all arithmetic is unsigned 32-bit. The timer wraps 32'hFFFF_FFFF → 0 naturally when CMP = 32'hFFFF_FFFF.
- Reset mid-operation:
  - All registers return to their reset values immediately.
  - RAM contents are not reset.
  - MemoryData then reflects the reset register values.

## Timing
- Load latency is 0 cycles (combinational). The store is visible to a load in the next cycle.
- Pin to PORT_IN: a pin change before edge n is readable after edge n+1.
- PIN_EVT sets at edge n+2.
- BusError is asserted the cycle after the offending access and lasts exactly 1 cycle.
- Timer with CMP = C, enabled from count 0: MATCH sets on edge C+1, at which point the count becomes 0.
- Reset state:
  - PortOut = 0, BusError = 0.
  - Sync/prev flops, PIN_EVT, TIMER_CNT and CTRL = 0.
  - TIMER_CMP = all ones.

## Structure
- Package mips_bus_pkg holds:
  - the register offset constants (OFS_PORT_OUT … OFS_CTRL);
  - the CTRL bit indices;
  - the reset constants (CMP_RESET);
  - the default base addresses.
- Sub-module mips_pin_sync (parameter WIDTH = 8) contains the two-flop synchronizer, the prev flop and the per-bit change pulse. The responder keeps the sticky PIN_EVT flags.
- The RAM is an inferred array with asynchronous read and synchronous write, inside the responder.

## Test plan
- Store/load RAM:
  - Store 32'hDEADBEEF to 0x1001_0004, then load 0x1001_0004 → 32'hDEADBEEF.
  - Load 0x1001_0000 → no corruption from the 0x1001_0004 store.
  - Store to DATA_BASE + 4·512 → BusError pulses once and RAM is unchanged.
- PortOut and read-only:
  - Store 32'h0000_00A5 to 0xFFFF_0000 → PortOut = 32'hA5 on the next cycle.
  - Store to 0xFFFF_0004 → ignored, with no BusError.
- Pin sync and events:
  - Change PortIn 0x00 → 0x81 → PORT_IN reads 0x81 after 2 edges, and PIN_EVT reads 0x81 after 3 edges.
  - W1C 0x01 → PIN_EVT = 0x80.
  - A W1C that coincides with a new pin-0 change → bit 0 stays set.
- Timer:
  - CMP = 3, TMR_EN = 1 → count runs 0,1,2,3,0 and MATCH sets on the wrap edge.
  - Writing CNT = 10 on the match cycle → count = 10 and MATCH is still set.
  - W1C bit1 → MATCH = 0.
- Reset:
  - Assert reset asynchronously mid-timer-run with PortOut = 0xFF → all outputs and registers return to their reset values at once, without waiting for an edge.
  - The RAM word written earlier still reads back intact.

Source files
------------

// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_bus_pkg : register map and reset constants of the data bus       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mips_bus_pkg;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
  localparam logic [31:0] IO_BASE_DEFAULT   = 32'hFFFF_0000;

  localparam logic [31:0] OFS_PORT_OUT  = 32'h00;
  localparam logic [31:0] OFS_PORT_IN   = 32'h04;
  localparam logic [31:0] OFS_PIN_EVT   = 32'h08;
  localparam logic [31:0] OFS_TIMER_CNT = 32'h0C;
  localparam logic [31:0] OFS_TIMER_CMP = 32'h10;
  localparam logic [31:0] OFS_CTRL      = 32'h14;

  localparam int CTRL_TMR_EN = 0;
  localparam int CTRL_MATCH  = 1;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mips_pin_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_pin_sync : two-flop pin synchronizer with per-bit change pulse   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mips_pin_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] change
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign sync   = r_sync2;
  assign change = r_sync2 ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/mips_data_bus_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_data_bus_responder : MEM-stage data RAM, PortOut/PortIn, timer   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mips_data_bus_responder
  import mips_bus_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [7:0]  PortIn,
  output logic [31:0] MemoryData,
  output logic [31:0] PortOut,
  output logic        BusError
);

  localparam int          AW        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEMORY_DEPTH * 4);

  logic [31:0]   w_addr;
  logic [31:0]   w_ram_ofs;
  logic [31:0]   w_io_ofs;
  logic          w_ram_hit;
  logic          w_io_hit;
  logic [AW-1:0] w_ram_idx;
  logic          w_unused;

  logic [31:0] mem [MEMORY_DEPTH];

  logic [31:0] r_port_out;
  logic [7:0]  r_pin_evt;
  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic        r_tmr_en;
  logic        r_match;
  logic        r_bus_error;

  logic [7:0]  w_pin_sync;
  logic [7:0]  w_pin_change;
  logic        w_wr_port_out;
  logic        w_wr_evt;
  logic        w_wr_cnt;
  logic        w_wr_cmp;
  logic        w_wr_ctrl;
  logic        w_match_now;
  logic [31:0] w_cnt_next;
  logic [31:0] w_ctrl;
  logic [31:0] w_rdata;

  // Byte lanes are ignored: every access is treated as a whole word.
  assign w_addr    = {ALUResult[31:2], 2'b00};
  assign w_ram_ofs = w_addr - DATA_BASE;
  assign w_io_ofs  = w_addr - IO_BASE;
  assign w_ram_hit = (w_addr >= DATA_BASE) && (w_ram_ofs < RAM_BYTES);
  assign w_io_hit  = (w_addr >= IO_BASE) && (w_io_ofs <= OFS_CTRL);
  assign w_ram_idx = w_ram_ofs[AW+1:2];
  assign w_unused  = ^{ALUResult[1:0], w_ram_ofs[31:AW+2], w_ram_ofs[1:0]};

  assign w_wr_port_out = MemWrite && w_io_hit && (w_io_ofs == OFS_PORT_OUT);
  assign w_wr_evt      = MemWrite && w_io_hit && (w_io_ofs == OFS_PIN_EVT);
  assign w_wr_cnt      = MemWrite && w_io_hit && (w_io_ofs == OFS_TIMER_CNT);
  assign w_wr_cmp      = MemWrite && w_io_hit && (w_io_ofs == OFS_TIMER_CMP);
  assign w_wr_ctrl     = MemWrite && w_io_hit && (w_io_ofs == OFS_CTRL);

  mips_pin_sync #(
    .WIDTH (8)
  ) u_pin_sync (
    .clk    (clk),
    .rst    (reset),
    .pin    (PortIn),
    .sync   (w_pin_sync),
    .change (w_pin_change)
  );

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) begin
      mem[w_ram_idx] <= ReadData2;
    end
  end

  // A CPU write to the count overrides the increment/wrap of that cycle.
  assign w_match_now = r_tmr_en && (r_cnt == r_cmp);

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_tmr_en) begin
      w_cnt_next = w_match_now ? 32'd0 : r_cnt + 32'd1;
    end
    if (w_wr_cnt) begin
      w_cnt_next = ReadData2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_out  <= '0;
      r_pin_evt   <= '0;
      r_cnt       <= '0;
      r_cmp       <= CMP_RESET;
      r_tmr_en    <= 1'b0;
      r_match     <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= (MemRead || MemWrite) && !w_ram_hit && !w_io_hit;
      r_cnt       <= w_cnt_next;
      r_pin_evt   <= (r_pin_evt & ~(w_wr_evt ? ReadData2[7:0] : 8'h00)) | w_pin_change;
      if (w_wr_port_out) r_port_out <= ReadData2;
      if (w_wr_cmp)      r_cmp      <= ReadData2;
      if (w_wr_ctrl)     r_tmr_en   <= ReadData2[CTRL_TMR_EN];
      if (w_match_now) begin
        r_match <= 1'b1;
      end else if (w_wr_ctrl && ReadData2[CTRL_MATCH]) begin
        r_match <= 1'b0;
      end
    end
  end

  always_comb begin
    w_ctrl              = '0;
    w_ctrl[CTRL_TMR_EN] = r_tmr_en;
    w_ctrl[CTRL_MATCH]  = r_match;
  end

  always_comb begin
    w_rdata = '0;
    if (MemRead) begin
      if (w_ram_hit) begin
        w_rdata = mem[w_ram_idx];
      end else if (w_io_hit) begin
        case (w_io_ofs)
          OFS_PORT_OUT:  w_rdata = r_port_out;
          OFS_PORT_IN:   w_rdata = {24'd0, w_pin_sync};
          OFS_PIN_EVT:   w_rdata = {24'd0, r_pin_evt};
          OFS_TIMER_CNT: w_rdata = r_cnt;
          OFS_TIMER_CMP: w_rdata = r_cmp;
          OFS_CTRL:      w_rdata = w_ctrl;
          default:       w_rdata = '0;
        endcase
      end
    end
  end

  assign MemoryData = w_rdata;
  assign PortOut    = r_port_out;
  assign BusError   = r_bus_error;

endmodule
`default_nettype wire
